exec_ctrl: RTL and testbench
============================

# exec_ctrl

Run/step/load sequencer for the single-cycle CPU. It sits between the debounced button pulses (`erase_shake` outputs) and the CPU core, and it gates the CPU's state-update enable. It holds the core in reset while a program image is streamed into instruction memory, and supports free-run, single-step and halt with a retired-instruction counter. Instruction memory write port and CPU enable/hold are owned exclusively by this block.

## Interface
Parameters:
- `ADDR_W`, 14: instruction-memory word-address width.
- `TIMEOUT`, 1_000_000: idle cycles allowed in LOAD before abort.

Ports:
- `clock` in 1: CPU clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `load_req` in 1: one-cycle pulse; enter program-load mode.
- `run_req` in 1: one-cycle pulse; free-run.
- `step_req` in 1: one-cycle pulse; execute one instruction.
- `halt_req` in 1: one-cycle pulse; stop execution.
- `halt_instr` in 1: CPU decoded a halt instruction this cycle.
- `ld_valid` in 1: loader word valid.
- `ld_last` in 1: qualifies final word of image.
- `ld_data` in 32: loader word.
- `ld_ready` out 1: block accepts loader words.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out ADDR_W: word address.
- `imem_wdata` out 32: write data.
- `cpu_en` out 1: CPU PC/register/memory update enable.
- `cpu_hold` out 1: CPU synchronous reset (PC forced to 0).
- `state` out 3: IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4.
- `retired` out 32: count of cycles with `cpu_en`=1.
- `err` out 2: bit0 load overflow, bit1 load timeout; sticky.

## Operation
- Reset values: state=IDLE, `cpu_hold`=1, `cpu_en`=0, `ld_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `retired`=0, `err`=0.
- Request priority when simultaneous: `load_req` > `halt_req` > `run_req` > `step_req`. A request that is illegal in the current state is dropped, not queued.
- IDLE: `cpu_hold`=1.
  - `load_req` → LOAD.
  - `run_req` → RUN.
  - `step_req` → STEP.
- LOAD: `cpu_hold`=1, `ld_ready`=1.
  - Entry clears the word counter, the timeout counter and `err`.
  - Each `ld_valid` cycle registers `imem_we`=1, `imem_addr`=counter and `imem_wdata`=`ld_data`, then increments the counter.
  - `ld_valid`&`ld_last` → IDLE after writing the word; `retired` clears.
  - Write at counter = 2^ADDR_W−1 without `ld_last` → write the word, set `err[0]`, → IDLE. The counter never wraps.
  - `TIMEOUT` consecutive cycles without `ld_valid` → set `err[1]`, → IDLE.
  - `halt_req`, `run_req` and `step_req` are ignored in LOAD.
- RUN: `cpu_hold`=0, `cpu_en`=1, `retired`++ every cycle.
  - `halt_req` or `halt_instr` → HALT. The halt instruction itself retires.
  - `load_req` → LOAD.
- STEP: `cpu_en`=1 for exactly one cycle, `retired`++, then → HALT unconditionally. Requests arriving during STEP are dropped.
- HALT: `cpu_en`=0, `cpu_hold`=0; CPU state is preserved.
  - `run_req` → RUN.
  - `step_req` → STEP.
  - `load_req` → LOAD.
- `retired` wraps modulo 2^32. `err` holds until the next LOAD entry or reset.

## Timing
- Moore outputs, registered. A request sampled at edge k takes effect in the state at k and in the outputs during cycle k+1.
- Load write latency is 1 cycle: `ld_valid` at edge k gives `imem_we` high for cycle k+1. Sustained throughput is 1 word/cycle. `ld_ready` deasserts in the cycle after the last/overflow word is accepted.
- STEP produces exactly one `cpu_en` high cycle. In RUN, `cpu_en` drops on the cycle after `halt_instr` is sampled.
- `reset` assertion mid-LOAD or mid-RUN clears all outputs immediately (asynchronous). Release is on a clock edge, into IDLE.

## Test plan
- Reset, `load_req`, then 4 words 0x11,0x22,0x33,0x44 with `ld_last` on the 4th → `imem_we` 4 cycles at addr 0..3 with matching data, state returns to IDLE, `err`=0.
- IDLE, `step_req` ×3 spaced 5 cycles → exactly 3 single-cycle `cpu_en` pulses, `retired`=3, state=HALT, `cpu_hold`=0.
- `run_req`, `halt_instr` after 10 cycles → `retired`=11, state=HALT. Then `load_req` → `cpu_hold`=1, state=LOAD.
- LOAD with ADDR_W=3, 9 words, no `ld_last` → 8 writes (addr 0..7), `err[0]`=1, IDLE, 9th word not written.
- LOAD with TIMEOUT=16, no `ld_valid` → IDLE at 16th idle cycle, `err[1]`=1. Same-cycle `load_req`+`run_req` in HALT → LOAD.
- Assert `reset` during RUN mid-cycle → `cpu_en`=0, `cpu_hold`=1, `retired`=0 before the next edge.

Source files
------------

// File: rtl/exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_ctrl : run/step/load sequencer gating CPU update enable & hold  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module exec_ctrl #(
   parameter int ADDR_W  = 14,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_req,
   input  logic              run_req,
   input  logic              step_req,
   input  logic              halt_req,
   input  logic              halt_instr,
   input  logic              ld_valid,
   input  logic              ld_last,
   input  logic [31:0]       ld_data,
   output logic              ld_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_en,
   output logic              cpu_hold,
   output logic [2:0]        state,
   output logic [31:0]       retired,
   output logic [1:0]        err
);

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_LOAD = 3'd1;
   localparam logic [2:0] c_RUN  = 3'd2;
   localparam logic [2:0] c_STEP = 3'd3;
   localparam logic [2:0] c_HALT = 3'd4;

   localparam int                c_TO_W     = $clog2(TIMEOUT + 1);
   localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_word_cnt;
   logic [c_TO_W-1:0] r_idle_cnt;
   logic              r_imem_we;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [31:0]       r_imem_wdata;
   logic [31:0]       r_retired;
   logic [1:0]        r_err;

   logic [2:0]        w_next_state;
   logic              w_load_entry;
   logic              w_at_max;

   assign w_at_max = (r_word_cnt == c_ADDR_MAX);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (load_req)      w_next_state = c_LOAD;
            else if (run_req)  w_next_state = c_RUN;
            else if (step_req) w_next_state = c_STEP;
         end
         c_LOAD: begin
            if (ld_valid && (ld_last || w_at_max))
               w_next_state = c_IDLE;
            else if (!ld_valid && (r_idle_cnt == c_TO_LAST))
               w_next_state = c_IDLE;
         end
         c_RUN: begin
            if (load_req)                    w_next_state = c_LOAD;
            else if (halt_req || halt_instr) w_next_state = c_HALT;
         end
         c_STEP: w_next_state = c_HALT;
         c_HALT: begin
            if (load_req)      w_next_state = c_LOAD;
            else if (run_req)  w_next_state = c_RUN;
            else if (step_req) w_next_state = c_STEP;
         end
         default: w_next_state = c_IDLE;
      endcase
   end

   assign w_load_entry = (w_next_state == c_LOAD) && (r_state != c_LOAD);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= c_IDLE;
         r_word_cnt   <= '0;
         r_idle_cnt   <= '0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_retired    <= '0;
         r_err        <= '0;
      end else begin
         r_state   <= w_next_state;
         r_imem_we <= 1'b0;

         if (w_load_entry) begin
            r_word_cnt <= '0;
            r_idle_cnt <= '0;
            r_err      <= '0;
         end else if (r_state == c_LOAD) begin
            if (ld_valid) begin
               r_imem_we    <= 1'b1;
               r_imem_addr  <= r_word_cnt;
               r_imem_wdata <= ld_data;
               r_idle_cnt   <= '0;
               // The counter parks at the top address so it can never wrap
               if (!ld_last && w_at_max)
                  r_err[0] <= 1'b1;
               else if (!w_at_max)
                  r_word_cnt <= r_word_cnt + 1'b1;
            end else if (r_idle_cnt == c_TO_LAST) begin
               r_err[1] <= 1'b1;
            end else begin
               r_idle_cnt <= r_idle_cnt + 1'b1;
            end
         end

         if ((r_state == c_LOAD) && ld_valid && ld_last)
            r_retired <= '0;
         else if ((r_state == c_RUN) || (r_state == c_STEP))
            r_retired <= r_retired + 32'd1;
      end
   end

   assign state      = r_state;
   assign cpu_en     = (r_state == c_RUN) || (r_state == c_STEP);
   assign cpu_hold   = (r_state == c_IDLE) || (r_state == c_LOAD);
   assign ld_ready   = (r_state == c_LOAD);
   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign retired    = r_retired;
   assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exec_ctrl : directed + random bench for exec_ctrl vs cycle model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_exec_ctrl;

   localparam int ADDR_W  = 3;
   localparam int TIMEOUT = 16;
   localparam int DEPTH   = 1 << ADDR_W;

   logic              clock;
   logic              reset;
   logic              load_req, run_req, step_req, halt_req, halt_instr;
   logic              ld_valid, ld_last;
   logic [31:0]       ld_data;
   logic              ld_ready, imem_we, cpu_en, cpu_hold;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata, retired;
   logic [2:0]        state;
   logic [1:0]        err;

   exec_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset),
      .load_req(load_req), .run_req(run_req), .step_req(step_req),
      .halt_req(halt_req), .halt_instr(halt_instr),
      .ld_valid(ld_valid), .ld_last(ld_last), .ld_data(ld_data),
      .ld_ready(ld_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .cpu_en(cpu_en), .cpu_hold(cpu_hold),
      .state(state), .retired(retired), .err(err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: mode as a plain integer plus counts of words and idle cycles
   int          m_state;
   int          m_cnt;
   int          m_idle;
   logic [31:0] m_retired;
   logic [1:0]  m_err;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;

   logic [31:0] img [DEPTH];
   int          wr_cnt = 0;
   int          en_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_idle = 0;
      m_retired = 0; m_err = 0; m_we = 0; m_addr = 0; m_wdata = 0;
   endtask

   task automatic enter_load();
      m_state = 1; m_cnt = 0; m_idle = 0; m_err = 0;
   endtask

   task automatic model_edge();
      m_we = 0;
      case (m_state)
         0: if (load_req) enter_load(); else if (run_req) m_state = 2; else if (step_req) m_state = 3;
         1: begin
            if (ld_valid) begin
               m_idle = 0; m_we = 1; m_addr = 32'(m_cnt); m_wdata = ld_data;
               if (ld_last) begin m_state = 0; m_retired = 0; end
               else if (m_cnt == DEPTH - 1) begin m_err[0] = 1'b1; m_state = 0; end
               else m_cnt++;
            end else begin
               m_idle++;
               if (m_idle == TIMEOUT) begin m_err[1] = 1'b1; m_state = 0; end
            end
         end
         2: begin
            m_retired = m_retired + 1;
            if (load_req) enter_load(); else if (halt_req || halt_instr) m_state = 4;
         end
         3: begin m_retired = m_retired + 1; m_state = 4; end
         default: if (load_req) enter_load(); else if (run_req) m_state = 2; else if (step_req) m_state = 3;
      endcase
   endtask

   task automatic check_all();
      chk("state", 32'(state), 32'(m_state));
      chk("cpu_en", 32'(cpu_en), 32'(m_state == 2 || m_state == 3));
      chk("cpu_hold", 32'(cpu_hold), 32'(m_state == 0 || m_state == 1));
      chk("ld_ready", 32'(ld_ready), 32'(m_state == 1));
      chk("imem_we", 32'(imem_we), 32'(m_we));
      chk("imem_addr", 32'(imem_addr), m_addr);
      chk("imem_wdata", imem_wdata, m_wdata);
      chk("retired", retired, m_retired);
      chk("err", 32'(err), 32'(m_err));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      model_edge();
      check_all();
      if (imem_we) begin img[imem_addr] = imem_wdata; wr_cnt++; end
      if (cpu_en) en_cnt++;
   endtask

   task automatic req(input logic l, input logic h, input logic r, input logic s);
      load_req = l; halt_req = h; run_req = r; step_req = s;
      tick();
      load_req = 0; halt_req = 0; run_req = 0; step_req = 0;
   endtask

   task automatic word(input logic [31:0] d, input logic last);
      ld_valid = 1; ld_data = d; ld_last = last;
      tick();
      ld_valid = 0; ld_last = 0;
   endtask

   initial begin
      int          wr0;
      logic [31:0] r0;
      reset = 0;
      load_req = 0; run_req = 0; step_req = 0; halt_req = 0; halt_instr = 0;
      ld_valid = 0; ld_last = 0; ld_data = 0;
      #2;
      model_reset();
      check_all();
      @(posedge clock); @(negedge clock);
      reset = 1;
      tick();

      // four-word image with ld_last on the final word
      req(1, 0, 0, 0);
      word(32'h11, 0); word(32'h22, 0); word(32'h33, 0); word(32'h44, 1);
      tick();
      chk("load4_img0", img[0], 32'h11);
      chk("load4_img1", img[1], 32'h22);
      chk("load4_img2", img[2], 32'h33);
      chk("load4_img3", img[3], 32'h44);
      chk("load4_writes", 32'(wr_cnt), 32'd4);
      chk("load4_state", 32'(state), 32'd0);
      chk("load4_err", 32'(err), 32'd0);

      // three single steps
      for (int i = 0; i < 3; i++) begin
         req(0, 0, 0, 1);
         repeat (4) tick();
      end
      chk("step_pulses", 32'(en_cnt), 32'd3);
      chk("step_retired", retired, 32'd3);
      chk("step_state", 32'(state), 32'd4);
      chk("step_hold", 32'(cpu_hold), 32'd0);

      // free run ended by a halt instruction that itself retires
      r0 = retired;
      req(0, 0, 1, 0);
      repeat (10) tick();
      halt_instr = 1; tick(); halt_instr = 0;
      chk("run_retired", retired, r0 + 32'd11);
      chk("run_state", 32'(state), 32'd4);
      req(1, 0, 0, 0);
      chk("halt_load_hold", 32'(cpu_hold), 32'd1);
      chk("halt_load_state", 32'(state), 32'd1);

      // overflow: nine words without ld_last into an eight-word memory
      wr0 = wr_cnt;
      for (int i = 0; i < 9; i++) word(32'h100 + 32'(i), 0);
      tick();
      chk("ovf_writes", 32'(wr_cnt - wr0), 32'd8);
      chk("ovf_img7", img[7], 32'h107);
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_state", 32'(state), 32'd0);

      // timeout with no loader activity
      req(1, 0, 0, 0);
      chk("to_clear_err", 32'(err), 32'd0);
      repeat (TIMEOUT - 1) tick();
      chk("to_still_load", 32'(state), 32'd1);
      tick();
      chk("to_state", 32'(state), 32'd0);
      chk("to_err", 32'(err), 32'd2);

      // simultaneous load and run in HALT favour load
      req(0, 0, 0, 1);
      tick();
      req(1, 0, 1, 0);
      chk("prio_state", 32'(state), 32'd1);
      word(32'hdead_beef, 1);

      // asynchronous reset in the middle of a RUN cycle
      req(0, 0, 1, 0);
      repeat (3) tick();
      #2 reset = 0;
      #1;
      model_reset();
      chk("arst_en", 32'(cpu_en), 32'd0);
      chk("arst_hold", 32'(cpu_hold), 32'd1);
      chk("arst_retired", retired, 32'd0);
      check_all();
      @(negedge clock);
      reset = 1;
      tick();

      for (int cyc = 0; cyc < 3000; cyc++) begin
         load_req   = ($urandom_range(0, 31) == 0);
         halt_req   = ($urandom_range(0, 15) == 0);
         run_req    = ($urandom_range(0, 15) == 0);
         step_req   = ($urandom_range(0, 15) == 0);
         halt_instr = ($urandom_range(0, 15) == 0);
         ld_valid   = ((cyc / 250) % 2 == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
         ld_last    = ($urandom_range(0, 5) == 0);
         ld_data    = $urandom;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
